// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit: holds the PC, fetches 64-bit beats over AR/R, hands {pc, inst} to decode.
// Define YSYX_22050133_IFU_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module ysyx_22050133_ifu #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    output logic [2:0]        arsize,
    input  logic [63:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_fault,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef YSYX_22050133_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt
`endif
);

    localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'b011;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_req;
    logic [ADDR_W-1:0] ar_addr;
    logic              kill;
    logic [ADDR_W-1:0] fetch_pc;

    function automatic logic [ADDR_W-1:0] align8(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:3], 3'b000};
    endfunction

    assign arsize = AXI_SIZE_BYTES_8;
    // ar_addr is registered separately from pc_req so a redirect can retarget
    // pc_req without disturbing a request that is still waiting for arready.
    assign araddr = ar_addr;

    // Target of the next request issued when the FSM (re)enters REQ.
    always_comb begin
        fetch_pc = pc_req;
        if (redirect_valid)
            fetch_pc = redirect_pc;
        else if (state == HOLD)
            fetch_pc = pc + ADDR_W'(4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc_req     <= RESET_PC;
            ar_addr    <= align8(RESET_PC);
            kill       <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_fault <= 1'b0;
            pc         <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    pc_req  <= fetch_pc;
                    ar_addr <= align8(fetch_pc);
                    arvalid <= 1'b1;
                    state   <= REQ;
                end
                REQ: begin
                    if (redirect_valid) begin
                        kill   <= 1'b1;
                        pc_req <= redirect_pc;
                    end
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (kill || redirect_valid) begin
                            kill    <= 1'b0;
                            pc_req  <= fetch_pc;
                            ar_addr <= align8(fetch_pc);
                            arvalid <= 1'b1;
                            state   <= REQ;
                        end else begin
                            inst       <= pc_req[2] ? rdata[63:32] : rdata[31:0];
                            pc         <= pc_req;
                            inst_fault <= (rresp != 2'b00);
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill   <= 1'b1;
                        pc_req <= redirect_pc;
                    end
                end
                HOLD: begin
                    // A redirect takes priority over a same-cycle handshake.
                    if (redirect_valid || inst_ready) begin
                        inst_valid <= 1'b0;
                        pc_req     <= fetch_pc;
                        ar_addr    <= align8(fetch_pc);
                        arvalid    <= 1'b1;
                        state      <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef YSYX_22050133_IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 64'h0;
            perf_stall_cnt <= 64'h0;
        end else begin
            if (inst_valid && inst_ready && !redirect_valid)
                perf_fetch_cnt <= perf_fetch_cnt + 64'h1;
            if ((state == HOLD && !inst_ready) || (state == WAIT && !rvalid))
                perf_stall_cnt <= perf_stall_cnt + 64'h1;
        end
    end
`else
    // Counters absent; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Self-checking bench for ysyx_22050133_ifu: memory responder, vector table, redirect/reset sequences.
// Build with YSYX_22050133_IFU_PERF_EN defined to also check the perf counters.
module tb_ysyx_22050133_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic [63:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arsize;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
`ifdef YSYX_22050133_IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ysyx_22050133_ifu #(.ADDR_W(64), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .inst(inst), .pc(pc), .inst_fault(inst_fault), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef YSYX_22050133_IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
        logic [1:0]  resp;
        int          stall;
        int          lat;
        int          ar_stall;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] arq[$];

    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;

    // Memory responder state
    logic        pend = 1'b0;
    logic [63:0] pend_addr = 64'h0;
    int          pend_delay = 0;
    int          mem_lat = 0;
    logic [1:0]  resp_next = 2'b00;
    int          ar_stall = 0;
    int          ar_cnt = 0;
    logic        ar_fired = 1'b0;
    logic        ar_waiting = 1'b0;
    logic [63:0] ar_held = 64'h0;

    function automatic logic [31:0] word(input logic [63:0] a);
        if (a == 64'h8000_0000) return 32'h0000_0013;
        if (a == 64'h8000_0004) return 32'h0010_0093;
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not occur (got none, expected one)", name);
    endtask

    task automatic push_exp(input logic [63:0] p, input logic f);
        exp_t e;
        e.pc = p;
        e.inst = word(p);
        e.fault = f;
        sbq.push_back(e);
    endtask

    // One clock: observe handshakes completing at the coming edge, then update the memory side.
    task automatic tick();
        logic ar_fire, r_fire, d_fire;
        logic [63:0] a;
        exp_t e;
        ar_fire = arvalid && arready && !rst;
        r_fire  = rvalid && rready;
        d_fire  = inst_valid && inst_ready && !redirect_valid && !rst;
        a = araddr;
        if (d_fire) begin
            if (sbq.size() == 0) fail_now("unexpected_inst");
            else begin
                e = sbq.pop_front();
                chk("inst", {32'h0, inst}, {32'h0, e.inst});
                chk("pc", pc, e.pc);
                chk("inst_fault", {63'h0, inst_fault}, {63'h0, e.fault});
            end
            n_pop++;
        end
        if (ar_fire) begin
            if (arq.size() == 0) fail_now("unexpected_ar");
            else chk("araddr", a, arq.pop_front());
            ar_fired = 1'b1;
            ar_cnt = 0;
        end
        ar_waiting = arvalid && !arready && !rst;
        ar_held = a;
        @(posedge clk);
        #1;
        if (ar_waiting) chk("ar_stable", araddr, ar_held);
        if (r_fire) rvalid = 1'b0;
        if (ar_fire) begin
            pend = 1'b1;
            pend_addr = a;
            pend_delay = mem_lat;
        end
        if (pend && !rvalid) begin
            if (pend_delay == 0) begin
                rvalid = 1'b1;
                rdata = {word(pend_addr + 64'h4), word(pend_addr)};
                rresp = resp_next;
                pend = 1'b0;
            end else pend_delay--;
        end
        if (arvalid && ar_cnt < ar_stall) begin
            arready = 1'b0;
            ar_cnt++;
        end else arready = 1'b1;
    endtask

    // Runs until decode accepts one instruction, stalling `stall` cycles in HOLD first.
    task automatic run_fetch(input int stall);
        int held = 0;
        int cnt = 0;
        int start = n_pop;
        while (n_pop == start && cnt < 80) begin
            if (inst_valid && held < stall) begin
                inst_ready = 1'b0;
                chk("hold_no_ar", {63'h0, arvalid}, 64'h0);
                chk("hold_pc", pc, sbq[0].pc);
                chk("hold_inst", {32'h0, inst}, {32'h0, sbq[0].inst});
                held++;
            end else inst_ready = 1'b1;
            tick();
            cnt++;
        end
        inst_ready = 1'b0;
        if (n_pop == start) fail_now("fetch_timeout");
    endtask

    task automatic wait_ar();
        int cnt = 0;
        ar_fired = 1'b0;
        while (!ar_fired && cnt < 40) begin
            tick();
            cnt++;
        end
        if (!ar_fired) fail_now("ar_timeout");
    endtask

    task automatic wait_valid();
        int cnt = 0;
        inst_ready = 1'b0;
        while (!inst_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        if (!inst_valid) fail_now("valid_timeout");
    endtask

    initial begin
        vec_t vt[8];
`ifdef YSYX_22050133_IFU_PERF_EN
        logic [63:0] stall_before;
`endif
        vt[0] = '{64'h8000_0000, 32'h0000_0013, 1'b0, 2'b00, 0, 0, 0};
        vt[1] = '{64'h8000_0004, 32'h0010_0093, 1'b0, 2'b00, 0, 0, 0};
        vt[2] = '{64'h8000_0008, word(64'h8000_0008), 1'b0, 2'b00, 5, 0, 0};
        vt[3] = '{64'h8000_000C, word(64'h8000_000C), 1'b1, 2'b10, 0, 1, 0};
        vt[4] = '{64'h8000_0010, word(64'h8000_0010), 1'b0, 2'b00, 1, 0, 2};
        vt[5] = '{64'h8000_0014, word(64'h8000_0014), 1'b1, 2'b01, 0, 2, 0};
        vt[6] = '{64'h8000_0018, word(64'h8000_0018), 1'b0, 2'b00, 2, 0, 1};
        vt[7] = '{64'h8000_001C, word(64'h8000_001C), 1'b0, 2'b00, 0, 3, 0};

        rst = 1'b1;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = 64'h0;
        rresp = 2'b00;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        for (int i = 0; i < 3; i++) tick();

        chk("rst_arvalid", {63'h0, arvalid}, 64'h0);
        chk("rst_rready", {63'h0, rready}, 64'h0);
        chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst_inst", {32'h0, inst}, 64'h0);
        chk("rst_fault", {63'h0, inst_fault}, 64'h0);
        chk("rst_pc", pc, RESET_PC);
        chk("arsize", {61'h0, arsize}, 64'h3);

        rst = 1'b0;
        tick();
        chk("first_arvalid", {63'h0, arvalid}, 64'h1);
        chk("first_araddr", araddr, 64'h8000_0000);

        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.pc = vt[i].pc;
            e.inst = vt[i].inst;
            e.fault = vt[i].fault;
            sbq.push_back(e);
            arq.push_back({vt[i].pc[63:3], 3'b000});
            resp_next = vt[i].resp;
            mem_lat = vt[i].lat;
            ar_stall = vt[i].ar_stall;
`ifdef YSYX_22050133_IFU_PERF_EN
            stall_before = perf_stall_cnt;
`endif
            run_fetch(vt[i].stall);
`ifdef YSYX_22050133_IFU_PERF_EN
            if (i == 2) chk("perf_stall_hold", perf_stall_cnt - stall_before, 64'd5);
`endif
        end
        ar_stall = 0;
        mem_lat = 0;
        resp_next = 2'b00;

        // Redirect in WAIT with rvalid in the same cycle: that beat is dropped.
        arq.push_back(64'h8000_0020);
        wait_ar();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0100;
        arq.push_back(64'h8000_0100);
        tick();
        redirect_valid = 1'b0;
        chk("redir_wait_drop", {63'h0, inst_valid}, 64'h0);
        tick();
        chk("redir_wait_drop2", {63'h0, inst_valid}, 64'h0);
        push_exp(64'h8000_0100, 1'b0);
        run_fetch(0);

        // Two redirects while a slow response is outstanding: the last one wins.
        mem_lat = 3;
        arq.push_back(64'h8000_0100);
        wait_ar();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0200;
        tick();
        redirect_pc = 64'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        mem_lat = 0;
        arq.push_back(64'h8000_0300);
        push_exp(64'h8000_0300, 1'b0);
        run_fetch(0);

        // Redirect while REQ waits for arready: request still issues, response discarded.
        ar_stall = 3;
        arq.push_back(64'h8000_0300);
        arq.push_back(64'h8000_0400);
        chk("req_pending", {63'h0, arvalid}, 64'h1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_0400;
        tick();
        redirect_valid = 1'b0;
        push_exp(64'h8000_0400, 1'b0);
        run_fetch(0);
        ar_stall = 0;

        // Redirect in HOLD with inst_ready high: no handshake, unaligned target.
        arq.push_back(64'h8000_0400);
        wait_valid();
        chk("hold_pc_pre", pc, 64'h8000_0404);
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_050C;
        arq.push_back(64'h8000_0508);
        tick();
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        chk("redir_hold_drop", {63'h0, inst_valid}, 64'h0);
        push_exp(64'h8000_050C, 1'b0);
        run_fetch(0);
`ifdef YSYX_22050133_IFU_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, 64'(n_pop));
`endif

        // Reset while WAIT, stale beat arrives afterwards and must be ignored.
        mem_lat = 1;
        arq.push_back(64'h8000_0510);
        wait_ar();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_arvalid", {63'h0, arvalid}, 64'h0);
        chk("rst2_rready", {63'h0, rready}, 64'h0);
        chk("rst2_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst2_pc", pc, RESET_PC);
        tick();
        chk("stale_rready", {63'h0, rready}, 64'h0);
        chk("stale_inst_valid", {63'h0, inst_valid}, 64'h0);
        chk("rst2_arvalid_up", {63'h0, arvalid}, 64'h1);
`ifdef YSYX_22050133_IFU_PERF_EN
        chk("perf_fetch_rst", perf_fetch_cnt, 64'h0);
`endif
        rvalid = 1'b0;
        pend = 1'b0;
        mem_lat = 0;
        arq.push_back(64'h8000_0000);
        push_exp(64'h8000_0000, 1'b0);
        run_fetch(0);

        chk("sb_empty", 64'(sbq.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
